alu_seq_unit: RTL and testbench

//  Execute stage directly downstream of the 2's-complement unit.

---
 rtl/alu_seq_unit_pkg.sv | 52 +++++
 rtl/alu_seq_unit_if.sv | 35 +++
 rtl/alu_seq_unit_mul.sv | 56 +++++
 rtl/alu_seq_unit.sv | 131 +++++++++++++
 tb/tb_alu_seq_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the sequential execute-stage ALU.
// Holds the operand width, shift-amount width, the counter width, the opcode
// and FSM state encodings, and helpers that classify and evaluate opcodes.
// The complement unit upstream imports this package for the opcode values.
package alu_seq_unit_pkg;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;
    // The counter must hold WIDTH, the multiplier step count.
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_ROR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_ROR);
    endfunction

    // Result of every op that completes on the accepting edge. FWD passes the
    // already-selected second operand through. Shift opcodes only land here
    // with a zero shift amount, so they return DATA1 unchanged.
    function automatic logic [WIDTH-1:0] single_cycle_result(
        input alu_op_e          op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            ALU_FWD: r = b;
            ALU_ADD: r = a + b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Control-unit handshake and operand bus for alu_seq_unit.
// Signals:
//   start  - request, sampled only when the ALU is not busy
//   opcode - operation select
//   data1  - register operand
//   data2  - operand from the complement/immediate mux
//   result - registered result, held until the next op completes
//   zero   - registered (result == 0)
//   busy   - high while a multi-cycle op is running
//   done   - one-cycle completion pulse
// The master modport is the control unit; the slave modport is the ALU.
import alu_seq_unit_pkg::*;

interface alu_seq_unit_if;

    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, opcode, data1, data2,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, opcode, data1, data2,
        output result, zero, busy, done
    );

endinterface

// File: rtl/alu_seq_unit_mul.sv
// alu_mul_seq: shift-add multiplier that is stepped by its parent.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   load_i     - capture multiplicand/multiplier and clear the accumulator
//   step_i     - perform one shift-add step
//   mcand_i    - multiplicand
//   mplier_i   - multiplier
//   product_o  - accumulator value after the step pending this cycle, so the
//                parent can capture the final product on the last step edge
// Only the low WIDTH bits of the product are kept.
import alu_seq_unit_pkg::*;

module alu_mul_seq (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_d;

    // Add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign product_o = acc_d;

    // Load clears the accumulator; each step consumes one multiplier bit and
    // moves the multiplicand up one place.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: execute stage downstream of the 2's-complement unit.
// FWD/ADD/AND/OR complete on the accepting edge; MUL takes WIDTH run cycles
// and SLL/SRA/ROR take one run cycle per bit of shift amount.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, has priority over start
//   bus   - slave side of alu_seq_unit_if (start/opcode/data1/data2 in,
//           result/zero/busy/done out)
// One down-counter paces both the multiplier and the shifter; the shift
// working value lives in the latched DATA1 register.
import alu_seq_unit_pkg::*;

module alu_seq_unit (
    input  logic          clk,
    input  logic          reset,
    alu_seq_unit_if.slave bus
);

    state_e           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    alu_op_e          op_in;
    logic [SHAMT_W-1:0] amt_in;
    logic [WIDTH-1:0] shift_next;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_product;

    assign op_in  = alu_op_e'(bus.opcode);
    assign amt_in = bus.data2[SHAMT_W-1:0];

    alu_mul_seq u_mul (
        .clk       (clk),
        .reset     (reset),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (bus.data1),
        .mplier_i  (bus.data2),
        .product_o (mul_product)
    );

    // One-bit move of the shift working value for the latched opcode.
    always_comb begin
        shift_next = a_q;
        case (op_q)
            ALU_SLL: shift_next = a_q << 1;
            ALU_SRA: shift_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            ALU_ROR: shift_next = {a_q[0], a_q[WIDTH-1:1]};
            default: shift_next = a_q;
        endcase
    end

    // Next-state logic. In RUN the counter is decremented and the final
    // step's value is written to the result on the edge that leaves RUN.
    // Start is honoured from IDLE and FINISH alike, which allows
    // back-to-back issue.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mul_load = 1'b0;
        mul_step = 1'b0;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == ALU_MUL) begin
                    mul_step = 1'b1;
                end else begin
                    a_d = shift_next;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_FINISH;
                    result_d = (op_q == ALU_MUL) ? mul_product : shift_next;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d = op_in;
                    a_d  = bus.data1;
                    if (op_in == ALU_MUL) begin
                        mul_load = 1'b1;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = S_RUN;
                    end else if (is_shift(op_in) && (amt_in != '0)) begin
                        cnt_d   = CNT_W'(amt_in);
                        state_d = S_RUN;
                    end else begin
                        cnt_d    = '0;
                        result_d = single_cycle_result(op_in, bus.data1, bus.data2);
                        state_d  = S_FINISH;
                    end
                end
            end
        endcase

        zero_d = (result_d == '0);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_FWD;
            a_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_FINISH);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit.
// A latency/result reference model predicts result, zero, busy and done for
// every cycle; a compare process checks the DUT against it on each falling
// edge. Directed scenarios pin the model with hand-computed values, then a
// randomized phase drives random requests, operands and occasional resets.
module tb_alu_seq_unit;

    localparam logic [2:0] OP_FWD = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_ROR = 3'd7;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic checkEn;

    alu_seq_unit_if bus ();

    alu_seq_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected result of an op computed directly from its arithmetic meaning.
    function automatic logic [7:0] refResult(input logic [2:0] op,
                                             input logic [7:0] d1,
                                             input logic [7:0] d2);
        int          amt;
        logic [15:0] wide;
        logic [7:0]  r;
        amt = int'(d2[2:0]);
        case (op)
            OP_FWD: r = d2;
            OP_ADD: r = d1 + d2;
            OP_AND: r = d1 & d2;
            OP_OR:  r = d1 | d2;
            OP_MUL: begin
                wide = {8'h00, d1} * {8'h00, d2};
                r    = wide[7:0];
            end
            OP_SLL: r = d1 << amt;
            OP_SRA: r = $signed(d1) >>> amt;
            default: begin
                wide = {d1, d1} >> amt;
                r    = wide[7:0];
            end
        endcase
        return r;
    endfunction

    // Edges from the accepting edge (counted as 1) to the done pulse.
    function automatic int refLatency(input logic [2:0] op, input logic [7:0] d2);
        if (op == OP_MUL) return 9;
        if (op >= OP_SLL) return int'(d2[2:0]) + 1;
        return 1;
    endfunction

    // Reference model: an op accepted while not busy either completes at
    // once or is held for a number of remaining edges, then published.
    int         mRemain;
    logic [7:0] mPending;
    logic [7:0] mResult;
    logic       mBusy;
    logic       mDone;

    always @(posedge clk) begin
        if (reset) begin
            mRemain <= 0;
            mResult <= 8'h00;
            mBusy   <= 1'b0;
            mDone   <= 1'b0;
        end else if (mRemain > 0) begin
            if (mRemain == 1) begin
                mResult <= mPending;
                mBusy   <= 1'b0;
                mDone   <= 1'b1;
            end
            mRemain <= mRemain - 1;
        end else if (bus.start) begin
            if (refLatency(bus.opcode, bus.data2) == 1) begin
                mResult <= refResult(bus.opcode, bus.data1, bus.data2);
                mDone   <= 1'b1;
                mBusy   <= 1'b0;
            end else begin
                mPending <= refResult(bus.opcode, bus.data1, bus.data2);
                mRemain  <= refLatency(bus.opcode, bus.data2) - 1;
                mBusy    <= 1'b1;
                mDone    <= 1'b0;
            end
        end else begin
            mDone <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp_result", int'(bus.result), int'(mResult));
            checkOutput("cmp_zero",   int'(bus.zero),   int'(mResult == 8'h00));
            checkOutput("cmp_busy",   int'(bus.busy),   int'(mBusy));
            checkOutput("cmp_done",   int'(bus.done),   int'(mDone));
        end
    end

    // Waits (bounded) for done; reports cycles since accept and busy cycles.
    task automatic waitDone(input int startCycle, output int cycles, output int busyCycles);
        cycles     = startCycle;
        busyCycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(negedge clk);
            cycles++;
        end
        if (bus.done !== 1'b1) checkOutput("done_timeout", 0, 1);
    endtask

    // Issues one op from the current falling edge, scrambles the inputs
    // after the accepting edge, and waits for completion.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d1,
                                 input logic [7:0] d2,
                                 output int cycles, output int busyCycles);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.data1  = d1;
        bus.data2  = d2;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = 3'($urandom);
        bus.data1  = 8'($urandom);
        bus.data2  = 8'($urandom);
        waitDone(1, cycles, busyCycles);
    endtask

    initial begin
        int  cyc;
        int  bsy;
        logic sawDone;

        checks     = 0;
        errors     = 0;
        checkEn    = 1'b0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = OP_FWD;
        bus.data1  = 8'h00;
        bus.data2  = 8'h00;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        checkEn = 1'b1;

        $display("[TB] reset state");
        checkOutput("reset_result", int'(bus.result), 'h00);
        checkOutput("reset_zero",   int'(bus.zero),   1);
        checkOutput("reset_busy",   int'(bus.busy),   0);
        checkOutput("reset_done",   int'(bus.done),   0);
        repeat (2) @(negedge clk);

        $display("[TB] single-cycle ops");
        applyStimulus(OP_ADD, 8'h05, 8'hFD, cyc, bsy);
        checkOutput("add_result",  int'(bus.result), 'h02);
        checkOutput("add_zero",    int'(bus.zero),   0);
        checkOutput("add_latency", cyc, 1);
        checkOutput("add_busy",    bsy, 0);
        @(negedge clk);

        applyStimulus(OP_ADD, 8'h80, 8'h80, cyc, bsy);
        checkOutput("add_wrap_result", int'(bus.result), 'h00);
        checkOutput("add_wrap_zero",   int'(bus.zero),   1);
        applyStimulus(OP_OR, 8'h0F, 8'hF0, cyc, bsy);
        checkOutput("b2b_or_result",  int'(bus.result), 'hFF);
        checkOutput("b2b_or_latency", cyc, 1);
        @(negedge clk);

        $display("[TB] multiply");
        applyStimulus(OP_MUL, 8'h0D, 8'h0B, cyc, bsy);
        checkOutput("mul_result",  int'(bus.result), 'h8F);
        checkOutput("mul_latency", cyc, 9);
        checkOutput("mul_busy",    bsy, 8);
        @(negedge clk);
        applyStimulus(OP_MUL, 8'h14, 8'h14, cyc, bsy);
        checkOutput("mul_trunc_result", int'(bus.result), 'h90);
        @(negedge clk);

        $display("[TB] shifts");
        applyStimulus(OP_SRA, 8'h80, 8'h03, cyc, bsy);
        checkOutput("sra_result",  int'(bus.result), 'hF0);
        checkOutput("sra_latency", cyc, 4);
        @(negedge clk);
        applyStimulus(OP_ROR, 8'h01, 8'h01, cyc, bsy);
        checkOutput("ror_result",  int'(bus.result), 'h80);
        checkOutput("ror_latency", cyc, 2);
        @(negedge clk);
        applyStimulus(OP_SLL, 8'h5A, 8'h08, cyc, bsy);
        checkOutput("sll0_result",  int'(bus.result), 'h5A);
        checkOutput("sll0_latency", cyc, 1);
        @(negedge clk);

        $display("[TB] start while busy");
        bus.start  = 1'b1;
        bus.opcode = OP_MUL;
        bus.data1  = 8'h0D;
        bus.data2  = 8'h0B;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = OP_AND;
        bus.data1  = 8'hFF;
        bus.data2  = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(3, cyc, bsy);
        checkOutput("busy_start_result",  int'(bus.result), 'h8F);
        checkOutput("busy_start_latency", cyc, 9);
        @(negedge clk);

        $display("[TB] reset during run");
        bus.start  = 1'b1;
        bus.opcode = OP_MUL;
        bus.data1  = 8'h07;
        bus.data2  = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_result", int'(bus.result), 'h00);
        checkOutput("abort_zero",   int'(bus.zero),   1);
        checkOutput("abort_busy",   int'(bus.busy),   0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", int'(sawDone), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            bus.start  = ($urandom_range(0, 2) == 0);
            bus.opcode = 3'($urandom);
            bus.data1  = 8'($urandom);
            bus.data2  = 8'($urandom);
            reset      = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (12) @(negedge clk);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
